// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// Imported by the control-word decoder and the top-level sequencer.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ASB_B       = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_word.sv
// Pure state -> control-word decode; every field not named in a state stays 0.
module mips_ctrl_word
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.ir_write  = 1'b1;
                cw.alu_src_b = ASB_FOUR;
                cw.alu_op    = ALUOP_ADD;
                cw.pc_write  = 1'b1;
            end
            // Speculatively compute the branch target into ALUOut.
            S_DECODE: begin
                cw.alu_src_b = ASB_IMM_SH2;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = ASB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                cw.mem_read = 1'b1;
                cw.iord     = 1'b1;
            end
            S_MEMWB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_write = 1'b1;
                cw.iord      = 1'b1;
            end
            S_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = ASB_B;
                cw.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a   = 1'b1;
                cw.alu_src_b   = ASB_B;
                cw.alu_op      = ALUOP_SUB;
                cw.pc_src      = PCSRC_ALUOUT;
                cw.branch_cond = 1'b1;
            end
            S_ADDIWB: begin
                cw.reg_write = 1'b1;
            end
            S_JUMP: begin
                cw.pc_src   = PCSRC_JUMP;
                cw.pc_write = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: state register, opcode
// dispatch, PC-enable generation and reset gating of the write strobes.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit EN_BNE  = 1'b1,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         Alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    state_t     state, state_nxt;
    ctrl_word_t cw;
    logic       is_bne;
    logic       op_legal;

    assign is_bne = EN_BNE && (opcode == OP_BNE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        op_legal  = 1'b1;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        if (is_bne) state_nxt = S_BRANCH;
                        else        op_legal  = 1'b0;
                    end
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            // Writeback states, BRANCH, JUMP and unused encodings all return to FETCH.
            default:  state_nxt = S_FETCH;
        endcase
    end

    mips_ctrl_word u_ctrl_word (
        .state (state),
        .cw    (cw)
    );

    // Architectural side effects are held off while reset is high.
    assign pc_en      = !reset && (cw.pc_write || (cw.branch_cond && (zero ^ is_bne)));
    assign mem_write  = !reset && cw.mem_write;
    assign reg_write  = !reset && cw.reg_write;
    assign ir_write   = !reset && cw.ir_write;
    assign illegal_op = !reset && (state == S_DECODE) && !op_legal;

    assign iord       = cw.iord;
    assign mem_read   = cw.mem_read;
    assign reg_dst    = cw.reg_dst;
    assign mem_to_reg = cw.mem_to_reg;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign Alu_op     = cw.alu_op;
    assign pc_src     = cw.pc_src;
    assign dbg_state  = STATE_W'(state);

endmodule
